// File: rtl/pc_lut_bank.sv
`timescale 1ns/1ps
// Programmable multi-bank jump-target table: indexed lookups with one cycle of latency,
// a valid/ready write port, and a sequential engine that invalidates one bank at a time.
module pc_lut_bank #(
    parameter  int D     = 12,
    parameter  int A     = 5,
    parameter  int BANKS = 2,
    localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_lk_en,
    input  logic [BW-1:0] i_lk_bank,
    input  logic [A-1:0]  i_lk_addr,
    output logic [D-1:0]  o_target,
    output logic          o_target_vld,
    output logic          o_lk_done,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [BW-1:0] i_wr_bank,
    input  logic [A-1:0]  i_wr_addr,
    input  logic [D-1:0]  i_wr_data,
    input  logic          i_clr_req,
    input  logic [BW-1:0] i_clr_bank,
    output logic          o_busy
);

    // Storage is addressed as {bank, index}; slots for non-existent banks are never validated.
    localparam int             DEPTH    = 1 << (BW + A);
    localparam logic [BW:0]    NBANK    = (BW + 1)'(BANKS);
    localparam logic [A-1:0]   IDX_LAST = '1;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [A-1:0]       r_idx;
    logic [BW-1:0]      r_clr_bank;
    logic [DEPTH-1:0]   r_valid;
    logic [D-1:0]       r_mem [DEPTH];
    logic [D-1:0]       r_rd_data;
    logic               r_hit;
    logic               r_lk_done;

    logic               w_lk_bank_ok;
    logic               w_wr_bank_ok;
    logic               w_clr_bank_ok;
    logic [BW+A-1:0]    w_lk_ptr;
    logic [BW+A-1:0]    w_wr_ptr;
    logic [BW+A-1:0]    w_clr_ptr;
    logic               w_lk_blocked;
    logic               w_lk_hit;
    logic               w_wr_store;
    logic               w_clr_start;

    assign w_lk_bank_ok  = {1'b0, i_lk_bank}  < NBANK;
    assign w_wr_bank_ok  = {1'b0, i_wr_bank}  < NBANK;
    assign w_clr_bank_ok = {1'b0, i_clr_bank} < NBANK;
    assign w_lk_ptr      = {i_lk_bank, i_lk_addr};
    assign w_wr_ptr      = {i_wr_bank, i_wr_addr};
    assign w_clr_ptr     = {r_clr_bank, r_idx};

    // The whole bank being wiped reads as empty, even entries not yet reached by the sweep.
    assign w_lk_blocked  = (r_state == ST_CLEAR) && (i_lk_bank == r_clr_bank);
    assign w_lk_hit      = w_lk_bank_ok && (i_lk_addr != '0) && r_valid[w_lk_ptr] && !w_lk_blocked;

    assign o_wr_ready    = (r_state == ST_IDLE) && !i_clr_req;
    assign w_wr_store    = i_wr_valid && o_wr_ready && w_wr_bank_ok && (i_wr_addr != '0);
    assign w_clr_start   = (r_state == ST_IDLE) && i_clr_req && w_clr_bank_ok;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_clr_start) w_state_next = ST_CLEAR;
            ST_CLEAR: if (r_idx == IDX_LAST) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_clr_bank <= '0;
            r_valid    <= '0;
            r_hit      <= 1'b0;
            r_lk_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_clr_start) begin
                r_idx      <= '0;
                r_clr_bank <= i_clr_bank;
            end else if (r_state == ST_CLEAR) begin
                r_idx <= r_idx + 1'b1;
            end
            // Writes are only accepted in IDLE, so these two never touch the same cycle.
            if (r_state == ST_CLEAR) r_valid[w_clr_ptr] <= 1'b0;
            if (w_wr_store)          r_valid[w_wr_ptr]  <= 1'b1;
            r_lk_done <= i_lk_en;
            if (i_lk_en) r_hit <= w_lk_hit;
        end
    end

    // Data array without reset; a same-cycle write is seen by the next lookup only.
    always_ff @(posedge i_clk) begin
        if (w_wr_store) r_mem[w_wr_ptr] <= i_wr_data;
        if (i_lk_en)    r_rd_data       <= r_mem[w_lk_ptr];
    end

    assign o_target     = r_hit ? r_rd_data : '0;
    assign o_target_vld = r_hit;
    assign o_lk_done    = r_lk_done;
    assign o_busy       = (r_state == ST_CLEAR);

endmodule
